// File: rtl/sign_extend_16to32.sv
// Registered immediate extender: sign/zero extension with optional <<2,
// one-cycle latency, valid-qualified capture.
module sign_extend_16to32 #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    input  logic             zero_ext,
    input  logic             shift2,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

    generate
        if (IN_W < 2) begin : g_bad_in_w
            $error("sign_extend_16to32: IN_W must be at least 2");
        end
        if (OUT_W <= IN_W) begin : g_bad_out_w
            $error("sign_extend_16to32: OUT_W must exceed IN_W");
        end
    endgenerate

    logic             fill;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] out_d,  out_q;
    logic             vld_d,  vld_q;

    // Extension first, then the optional word-alignment shift; top bits drop off.
    always_comb begin
        fill  = in[IN_W-1] & ~zero_ext;
        ext   = {{(OUT_W-IN_W){fill}}, in};
        res   = shift2 ? {ext[OUT_W-3:0], 2'b00} : ext;
        out_d = in_valid ? res : out_q;
        vld_d = in_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_sign_extend_16to32.sv
// Directed bench for sign_extend_16to32: vector table plus reset,
// hold and async-reset sequences.
module tb_sign_extend_16to32;

    logic        clk;
    logic        reset_n;
    logic [15:0] in;
    logic        in_valid;
    logic        zero_ext;
    logic        shift2;
    logic [31:0] out;
    logic        out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    sign_extend_16to32 #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in),
        .in_valid  (in_valid),
        .zero_ext  (zero_ext),
        .shift2    (shift2),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] in;
        logic        zext;
        logic        sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic vld, input logic zx, input logic sh);
        in       = v;
        in_valid = vld;
        zero_ext = zx;
        shift2   = sh;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'hAD6A, 1'b0, 1'b0, 32'hFFFFAD6A};
        vecs[1]  = '{16'h2D6A, 1'b0, 1'b0, 32'h00002D6A};
        vecs[2]  = '{16'hED6A, 1'b0, 1'b0, 32'hFFFFED6A};
        vecs[3]  = '{16'hEDEA, 1'b0, 1'b0, 32'hFFFFEDEA};
        vecs[4]  = '{16'hAD6A, 1'b1, 1'b0, 32'h0000AD6A};
        vecs[5]  = '{16'h8000, 1'b1, 1'b0, 32'h00008000};
        vecs[6]  = '{16'hFFFF, 1'b0, 1'b1, 32'hFFFFFFFC};
        vecs[7]  = '{16'h4000, 1'b0, 1'b1, 32'h00010000};
        vecs[8]  = '{16'h8000, 1'b1, 1'b1, 32'h00020000};
        vecs[9]  = '{16'h8000, 1'b0, 1'b0, 32'hFFFF8000};
        vecs[10] = '{16'h7FFF, 1'b0, 1'b0, 32'h00007FFF};
        vecs[11] = '{16'hFFFF, 1'b0, 1'b0, 32'hFFFFFFFF};
        vecs[12] = '{16'h0000, 1'b0, 1'b0, 32'h00000000};

        // Reset held with a live input: nothing may be captured.
        reset_n = 1'b0;
        drive(16'hFFFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_out", out, 32'h0);
            check("reset_valid", {31'b0, out_valid}, 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("first_out", out, 32'hFFFFFFFF);
        check("first_valid", {31'b0, out_valid}, 32'h1);

        // Back-to-back table: valid must stay high every cycle.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].in, 1'b1, vecs[i].zext, vecs[i].sh);
            @(posedge clk); #1;
            check($sformatf("vec%0d_out", i), out, vecs[i].exp);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
        end

        // Hold: input and modes change while in_valid is low.
        drive(16'h1234, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("hold_cap_out", out, 32'h00001234);
        check("hold_cap_valid", {31'b0, out_valid}, 32'h1);
        drive(16'hFFFF, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("hold_out", out, 32'h00001234);
            check("hold_valid", {31'b0, out_valid}, 32'h0);
        end

        // Async reset between edges clears immediately.
        drive(16'hAD6A, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_out", out, 32'hFFFFAD6A);
        drive(16'h1234, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", out, 32'h0);
        check("async_rst_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk); #1;
        check("rst_edge_out", out, 32'h0);
        check("rst_edge_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out", out, 32'h00001234);
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
